leosoc_uart_tx: RTL
===================

// Module: leosoc_uart_tx
// PURPOSE
//   Byte-serialising UART transmitter for the LeoSoC peripheral bus, driving the serial line routed to mprj_io[6].
//   CPU stores go to the data port and are buffered in a small FIFO.
//   Frames are 8N1 (8-N-1 format), LSB first, with a runtime-programmable bit period.
//   Sits between the SoC bus decode (upstream) and the off-chip serial receiver (downstream).
// PARAMETERS
//   FIFO_DEPTH  8   entries in the TX FIFO; must be a power of two, >= 2
//   DIV_WIDTH   16  width of the bit-period divisor
// PORTS
//   wb_clk_i      in   1            system clock; the only clock
//   wb_rst_i      in   1            synchronous reset, active-high
//   div_i         in   DIV_WIDTH    bit period in clock cycles (e.g. 4167 = 9600 baud at 40 MHz)
//   data_i        in   8            byte to transmit
//   valid_i       in   1            data_i valid; written when valid_i && ready_o at the clock edge
//   ready_o       out  1            FIFO not full
//   tx_o          out  1            serial output; idle high; registered
//   busy_o        out  1            FSM not IDLE, or FIFO not empty
//   level_o       out  $clog2(FIFO_DEPTH)+1   FIFO occupancy
// BEHAVIOUR
// - Reset (sync, wb_rst_i=1 at an edge):
//   - tx_o=1, ready_o=1, busy_o=0, level_o=0.
//   - FSM=IDLE; FIFO pointers and bit counter cleared.
//   - Mid-frame reset aborts the frame; tx_o is 1 from the next edge on; queued bytes are discarded.
// - FIFO:
//   - Push when valid_i && ready_o; pop only when the FSM leaves IDLE.
//   - ready_o = (level_o != FIFO_DEPTH); it is not combinationally bypassed by a same-cycle pop.
//   - A push while full is ignored: no state change, no error.
//   - Push and pop in the same cycle leave level_o unchanged.
//   - Pointers wrap modulo FIFO_DEPTH.
// - Divisor:
//   - div_i is sampled into an internal register when a frame starts.
//   - Changes to div_i mid-frame take effect from the next frame.
//   - A sampled value < 2 is treated as 2.
//   - Each bit lasts exactly D cycles (D = sampled divisor); a frame is 10*D cycles (11*D with parity).
// - FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE/START
//   - IDLE: tx_o=1. If FIFO not empty: pop, latch byte and D, go to START.
//     tx_o=0 is registered on that same edge.
//     A byte pushed into an empty idle FIFO at edge N gives tx_o=0 from edge N+1.
//   - START: hold 0 for D cycles, then DATA with bit index 0.
//   - DATA: tx_o=byte[idx] for D cycles each, idx 0..7; after idx 7, go to PARITY or STOP.
//   - STOP: tx_o=1 for D cycles. Then, if FIFO not empty, pop and enter START directly (back-to-back frames, no extra idle cycle); else IDLE.
// - Counters:
//   - Bit-period counter counts D-1 down to 0; the state/bit advances when the counter is 0.
//   - Bit index is 3 bits.
// - busy_o is registered-consistent: it falls on the edge the FSM returns to IDLE with an empty FIFO.
// CONFIGURATION
//   UART_TX_PARITY_EN defined:
//     - Adds a PARITY state between DATA and STOP.
//     - tx_o = ^byte (even parity) for D cycles.
//     - Frame is 11*D cycles.
//   UART_TX_PARITY_EN undefined:
//     - No PARITY state and no parity logic; 8N1 framing, 10*D cycles per frame.
// TESTING
//   1 Hold reset 5 cycles, then release -> tx_o=1, ready_o=1, busy_o=0, level_o=0; no toggles for 100 cycles.
//   2 div_i=16, push 0x48 at edge N -> tx_o=0 from N+1 for 16 cycles, then 0,0,0,1,0,0,1,0 at 16 cycles each, then 1; busy_o=0 at N+161.
//   3 div_i=16, push 9 bytes 'H','e','l','l','o',0x0A,1,2,3 back-to-back ->
//     - level_o peaks at 8 and ready_o drops.
//     - 9th byte pushed only after the first pop.
//     - Frames are contiguous: stop bit directly followed by start bit.
//     - Bench receiver decodes "Hello\n" followed by 01,02,03.
//   4 Push valid_i while full (level_o=8, no pop) -> ignored; level_o stays 8; the 8 queued bytes transmit unchanged.
//   5 Reset asserted mid-DATA of a 3-deep queue -> tx_o=1 next edge; level_o=0; busy_o=0; no further start bits.
//   6 UART_TX_PARITY_EN, div_i=8, push 0x07 -> frame 0,1,1,1,0,0,0,0,0,parity=1,stop=1; 88 cycles total.
//     Push 0x48 -> parity bit 0.

Source files
------------

// File: rtl/leosoc_uart_tx.sv
// leosoc_uart_tx: FIFO-buffered 8N1 UART transmitter with a runtime bit period.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module leosoc_uart_tx #(
   parameter int FIFO_DEPTH = 8,
   parameter int DIV_WIDTH  = 16
) (
   input  logic                        wb_clk_i,
   input  logic                        wb_rst_i,
   input  logic [DIV_WIDTH-1:0]        div_i,
   input  logic [7:0]                  data_i,
   input  logic                        valid_i,
   output logic                        ready_o,
   output logic                        tx_o,
   output logic                        busy_o,
   output logic [$clog2(FIFO_DEPTH):0] level_o
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
   state_t state, state_n;
   logic [7:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [DIV_WIDTH-1:0] cnt, cnt_n, div_q, div_n, d_eff;
   logic [2:0] idx, idx_n;
   logic [7:0] shr, shr_n;
   logic tx_n, push, pop, has, last;
   assign has     = level_o != '0;
   assign last    = cnt == '0;
   assign ready_o = level_o != LW'(FIFO_DEPTH);
   assign busy_o  = state != IDLE || has;
   assign push    = valid_i && ready_o;
   assign d_eff   = div_i < DIV_WIDTH'(2) ? DIV_WIDTH'(2) : div_i;
   always_comb begin
      state_n = state;
      cnt_n   = state == IDLE ? cnt : cnt - DIV_WIDTH'(1);
      idx_n   = idx;
      tx_n    = tx_o;
      shr_n   = shr;
      div_n   = div_q;
      pop     = 1'b0;
      case (state)
         IDLE:  pop = has;
         START: if (last) begin
            state_n = DATA;
            idx_n   = 3'd0;
            tx_n    = shr[0];
            cnt_n   = div_q - DIV_WIDTH'(1);
         end
         DATA: if (last) begin
            cnt_n = div_q - DIV_WIDTH'(1);
            idx_n = idx + 3'd1;
            if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
               state_n = PARITY;
               tx_n    = ^shr;
`else
               state_n = STOP;
               tx_n    = 1'b1;
`endif
            end else
               tx_n = shr[idx + 3'd1];
         end
`ifdef UART_TX_PARITY_EN
         PARITY: if (last) begin
            state_n = STOP;
            tx_n    = 1'b1;
            cnt_n   = div_q - DIV_WIDTH'(1);
         end
`endif
         STOP: if (last) begin
            state_n = IDLE;
            pop     = has;
         end
         default: ;
      endcase
      // a pop always launches a start bit, from IDLE or straight out of STOP
      if (pop) begin
         state_n = START;
         tx_n    = 1'b0;
         shr_n   = mem[rd_ptr];
         div_n   = d_eff;
         cnt_n   = d_eff - DIV_WIDTH'(1);
      end
   end
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state   <= IDLE;
         cnt     <= '0;
         idx     <= '0;
         tx_o    <= 1'b1;
         shr     <= '0;
         div_q   <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_o <= '0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         idx     <= idx_n;
         tx_o    <= tx_n;
         shr     <= shr_n;
         div_q   <= div_n;
         if (push) begin
            mem[wr_ptr] <= data_i;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         level_o <= level_o + LW'(push) - LW'(pop);
      end
   end
endmodule
